uart_tx_formatter: RTL and testbench

//  Transmit-side counterpart of the UART RX parser/classifier. Accepts one response

---
 rtl/uart_tx_formatter_if.sv | 33 +++
 rtl/uart_tx_formatter.sv | 122 ++++++++++++
 tb/tb_uart_tx_formatter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_formatter_if.sv
// Response-request and byte-stream signals between sequencer, formatter and serializer.
// The formatter takes the slave side; sequencer/serializer/bench take the master side.
interface uart_tx_formatter_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_type;
  logic [7:0]       rsp_addr;
  logic [15:0]      rsp_offset;
  logic [31:0]      rsp_data;
  logic [31:0]      rsp_red;
  logic [31:0]      rsp_green;
  logic [31:0]      rsp_blue;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  modport slave (
    input  rsp_valid, rsp_type, rsp_addr, rsp_offset, rsp_data,
           rsp_red, rsp_green, rsp_blue, tx_ready,
    output rsp_ready, tx_data, tx_valid, busy, frame_done, frame_cnt
  );

  modport master (
    output rsp_valid, rsp_type, rsp_addr, rsp_offset, rsp_data,
           rsp_red, rsp_green, rsp_blue, tx_ready,
    input  rsp_ready, tx_data, tx_valid, busy, frame_done, frame_cnt
  );
endinterface

// File: rtl/uart_tx_formatter.sv
// Builds a {..,..,..} response frame from one sequencer request and streams it
// one byte per tx handshake, then pulses frame_done and counts the frame.
module uart_tx_formatter #(
  parameter int unsigned IDLE_GAP = 0,
  parameter int unsigned CNT_W    = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_formatter_if.slave bus
);
  localparam int unsigned GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state;
  logic [127:0]     frame;
  logic [4:0]       frame_len;
  logic [127:0]     buffer;
  logic [4:0]       remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic             rsp_ready_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] frame_cnt_q;

  // Frame image with byte0 in [7:0], so streaming is a plain right shift.
  always_comb begin
    frame     = '0;
    frame_len = 5'd6;
    case (bus.rsp_type)
      2'd0: begin
        frame = {8'h7D, 8'h00, bus.rsp_data[7:0], bus.rsp_data[15:8],
                 8'h56, 8'h2C, 8'h00, bus.rsp_data[23:16],
                 bus.rsp_data[31:24], 8'h56, 8'h2C, bus.rsp_offset[7:0],
                 bus.rsp_offset[15:8], bus.rsp_addr, 8'h52, 8'h7B};
        frame_len = 5'd16;
      end
      2'd1: begin
        frame = {8'h7D, bus.rsp_blue[7:0], bus.rsp_green[7:0], bus.rsp_red[7:0],
                 bus.rsp_blue[15:8], 8'h2C, bus.rsp_green[15:8], bus.rsp_red[15:8],
                 bus.rsp_blue[23:16], bus.rsp_green[23:16], 8'h2C, bus.rsp_red[23:16],
                 bus.rsp_blue[31:24], bus.rsp_green[31:24], bus.rsp_red[31:24], 8'h7B};
        frame_len = 5'd16;
      end
      2'd2: frame = {80'h0, 8'h7D, bus.rsp_offset[7:0], bus.rsp_offset[15:8],
                     bus.rsp_addr, 8'h41, 8'h7B};
      default: frame = {80'h0, 8'h7D, bus.rsp_offset[7:0], bus.rsp_offset[15:8],
                        bus.rsp_addr, 8'h4E, 8'h7B};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      buffer       <= '0;
      remaining    <= '0;
      gap_cnt      <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      rsp_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rsp_valid) begin
            state       <= SEND;
            buffer      <= frame;
            remaining   <= frame_len;
            tx_data_q   <= frame[7:0];
            tx_valid_q  <= 1'b1;
            rsp_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SEND: begin
          if (tx_valid_q && bus.tx_ready) begin
            if (remaining == 5'd1) begin
              tx_valid_q   <= 1'b0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 1'b1;
              if (IDLE_GAP == 0) begin
                state       <= IDLE;
                rsp_ready_q <= 1'b1;
                busy_q      <= 1'b0;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_W'(IDLE_GAP - 1);
              end
            end else begin
              buffer    <= buffer >> 8;
              tx_data_q <= buffer[15:8];
              remaining <= remaining - 1'b1;
            end
          end
        end
        GAP: begin
          // The ready flag is set on the last gap cycle so exactly IDLE_GAP cycles stay closed.
          if (gap_cnt == '0) begin
            state       <= IDLE;
            rsp_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.rsp_ready  = rsp_ready_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_uart_tx_formatter.sv
// Directed bench for uart_tx_formatter: a zero-gap 16-bit-counter instance and a
// 3-cycle-gap 2-bit-counter instance, with byte scoreboards fed at request time.
module tb_uart_tx_formatter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_formatter_if #(.CNT_W(16)) bus_a ();
  uart_tx_formatter_if #(.CNT_W(2))  bus_b ();

  uart_tx_formatter #(.IDLE_GAP(0), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  uart_tx_formatter #(.IDLE_GAP(3), .CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int tests = 0;
  int fails = 0;
  int rdy_mode = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int b_cnt_exp[5] = '{1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame layout, one byte per array slot in transmit order.
  function automatic void build(input logic [1:0] t, input logic [7:0] a, input logic [15:0] off,
                                input logic [31:0] d, r, g, b,
                                output logic [7:0] v[16], output int n);
    v = '{default: 8'h00};
    case (t)
      2'd0: begin
        v = '{8'h7B, 8'h52, a, off[15:8], off[7:0], 8'h2C, 8'h56, d[31:24], d[23:16], 8'h00,
              8'h2C, 8'h56, d[15:8], d[7:0], 8'h00, 8'h7D};
        n = 16;
      end
      2'd1: begin
        v = '{8'h7B, r[31:24], g[31:24], b[31:24], r[23:16], 8'h2C, g[23:16], b[23:16],
              r[15:8], g[15:8], 8'h2C, b[15:8], r[7:0], g[7:0], b[7:0], 8'h7D};
        n = 16;
      end
      default: begin
        v[0] = 8'h7B; v[1] = (t == 2'd2) ? 8'h41 : 8'h4E; v[2] = a;
        v[3] = off[15:8]; v[4] = off[7:0]; v[5] = 8'h7D;
        n = 6;
      end
    endcase
  endfunction

  task automatic drive_a(input logic [1:0] t, input logic [7:0] a, input logic [15:0] off,
                         input logic [31:0] d, r, g, b);
    bus_a.rsp_type = t; bus_a.rsp_addr = a; bus_a.rsp_offset = off;
    bus_a.rsp_data = d; bus_a.rsp_red = r; bus_a.rsp_green = g; bus_a.rsp_blue = b;
    bus_a.rsp_valid = 1'b1;
  endtask

  task automatic set_req_a(input logic [1:0] t, input logic [7:0] a, input logic [15:0] off,
                           input logic [31:0] d, r, g, b);
    logic [7:0] v[16];
    int n;
    build(t, a, off, d, r, g, b, v, n);
    for (int i = 0; i < n; i++) exp_a.push_back(v[i]);
    drive_a(t, a, off, d, r, g, b);
  endtask

  task automatic push_lit_a(input logic [7:0] v[16], input int n);
    for (int i = 0; i < n; i++) exp_a.push_back(v[i]);
  endtask

  task automatic drive_b(input int k);
    logic [7:0] v[16];
    int n;
    build(2'd2, 8'(8'h30 + k), 16'(k * 16'h0111), 32'h0, 32'h0, 32'h0, 32'h0, v, n);
    for (int i = 0; i < n; i++) exp_b.push_back(v[i]);
    bus_b.rsp_type = 2'd2; bus_b.rsp_addr = 8'(8'h30 + k); bus_b.rsp_offset = 16'(k * 16'h0111);
    bus_b.rsp_valid = 1'b1;
  endtask

  // Starts and ends on a negedge; checks byte0 appears the cycle after acceptance.
  task automatic accept_a(input bit hold, input string tag);
    for (int i = 0; i < 300 && !bus_a.rsp_ready; i++) @(negedge clk);
    check({tag, "_ready"}, bus_a.rsp_ready, 1);
    @(posedge clk); #1;
    if (!hold) bus_a.rsp_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat_valid"}, bus_a.tx_valid, 1);
    check({tag, "_lat_byte0"}, bus_a.tx_data, 8'h7B);
  endtask

  task automatic wait_done_a(input int exp_cnt, input string tag, output int vcnt);
    bit found = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (bus_a.frame_done) found = 1'b1;
      else if (bus_a.tx_valid) vcnt++;
    end
    check({tag, "_done"}, found, 1);
    check({tag, "_cnt"}, bus_a.frame_cnt, exp_cnt);
    check({tag, "_valid_low"}, bus_a.tx_valid, 0);
    check({tag, "_ready_back"}, bus_a.rsp_ready, 1);
  endtask

  initial begin
    bus_a.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus_a.tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
    end
  end

  logic       prev_stall_a = 1'b0;
  logic [7:0] prev_data_a = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall_a <= 1'b0;
    end else begin
      if (prev_stall_a) begin
        check("hold_valid", bus_a.tx_valid, 1);
        check("hold_data", bus_a.tx_data, prev_data_a);
      end
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        check("a_queue_nonempty", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) check("a_byte", bus_a.tx_data, exp_a.pop_front());
      end
      prev_stall_a <= bus_a.tx_valid && !bus_a.tx_ready;
      prev_data_a  <= bus_a.tx_data;
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_b.tx_valid && bus_b.tx_ready) begin
      check("b_queue_nonempty", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) check("b_byte", bus_b.tx_data, exp_b.pop_front());
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    logic [7:0] lit[16];
    int vcnt;
    int n;
    int g;
    bit found;

    rst = 1'b1;
    drive_a(2'd0, 8'h00, 16'h0000, 32'h0, 32'h0, 32'h0, 32'h0);
    bus_a.rsp_valid = 1'b0;
    bus_b.rsp_valid = 1'b0; bus_b.rsp_type = 2'd2; bus_b.rsp_addr = 8'h00;
    bus_b.rsp_offset = 16'h0; bus_b.rsp_data = 32'h0; bus_b.rsp_red = 32'h0;
    bus_b.rsp_green = 32'h0; bus_b.rsp_blue = 32'h0; bus_b.tx_ready = 1'b1;

    @(negedge clk);
    check("rst_rsp_ready", bus_a.rsp_ready, 1);
    check("rst_tx_valid", bus_a.tx_valid, 0);
    check("rst_tx_data", bus_a.tx_data, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_frame_done", bus_a.frame_done, 0);
    check("rst_frame_cnt", bus_a.frame_cnt, 0);
    check("rst_b_frame_cnt", bus_b.frame_cnt, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // RGF read data at full rate
    lit = '{8'h7B, 8'h52, 8'h05, 8'h00, 8'h12, 8'h2C, 8'h56, 8'hA1, 8'hB2, 8'h00,
            8'h2C, 8'h56, 8'hC3, 8'hD4, 8'h00, 8'h7D};
    push_lit_a(lit, 16);
    drive_a(2'd0, 8'h05, 16'h0012, 32'hA1B2C3D4, 32'h0, 32'h0, 32'h0);
    accept_a(1'b0, "rgf");
    check("rgf_busy", bus_a.busy, 1);
    check("rgf_rsp_ready_low", bus_a.rsp_ready, 0);
    wait_done_a(1, "rgf", vcnt);
    check("rgf_consecutive", vcnt + 1, 16);
    @(negedge clk);
    check("rgf_done_pulse", bus_a.frame_done, 0);

    // Pixel data
    lit = '{8'h7B, 8'h11, 8'h55, 8'h99, 8'h22, 8'h2C, 8'h66, 8'hAA, 8'h33, 8'h77,
            8'h2C, 8'hBB, 8'h44, 8'h88, 8'hCC, 8'h7D};
    push_lit_a(lit, 16);
    drive_a(2'd1, 8'h00, 16'h0000, 32'h0, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    accept_a(1'b0, "pix");
    wait_done_a(2, "pix", vcnt);

    // ACK then NACK back-to-back, request held across the busy period
    lit = '{8'h7B, 8'h41, 8'h20, 8'h01, 8'h00, 8'h7D, 8'h0, 8'h0, 8'h0, 8'h0,
            8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    push_lit_a(lit, 6);
    drive_a(2'd2, 8'h20, 16'h0100, 32'h0, 32'h0, 32'h0, 32'h0);
    accept_a(1'b1, "ack");
    lit[1] = 8'h4E; lit[2] = 8'h21; lit[3] = 8'h00; lit[4] = 8'h00;
    push_lit_a(lit, 6);
    drive_a(2'd3, 8'h21, 16'h0000, 32'h0, 32'h0, 32'h0, 32'h0);
    wait_done_a(3, "ack", vcnt);
    accept_a(1'b0, "nack");
    wait_done_a(4, "nack", vcnt);

    // Random backpressure on the serializer side
    rdy_mode = 1;
    set_req_a(2'd1, 8'h00, 16'h0000, 32'h0, $urandom, $urandom, $urandom);
    accept_a(1'b0, "bp_pix");
    wait_done_a(5, "bp_pix", vcnt);
    set_req_a(2'd0, 8'($urandom), 16'($urandom), $urandom, 32'h0, 32'h0, 32'h0);
    accept_a(1'b0, "bp_rgf");
    wait_done_a(6, "bp_rgf", vcnt);
    rdy_mode = 0;

    // tx_ready alone while idle must not start anything
    repeat (5) @(negedge clk);
    check("idle_tx_valid", bus_a.tx_valid, 0);
    check("idle_frame_cnt", bus_a.frame_cnt, 6);

    // Gap instance: 5 held ACK requests, 3 closed cycles after each frame, 2-bit count
    drive_b(0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 50 && !bus_b.rsp_ready; i++) @(negedge clk);
      check("b_ready", bus_b.rsp_ready, 1);
      @(posedge clk); #1;
      if (k < 4) drive_b(k + 1);
      else bus_b.rsp_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
        @(negedge clk);
        found = bus_b.frame_done;
      end
      check("b_done", found, 1);
      check("b_cnt", bus_b.frame_cnt, b_cnt_exp[k]);
      g = 0;
      for (int i = 0; i < 20 && !bus_b.rsp_ready; i++) begin
        check("b_gap_tx_valid", bus_b.tx_valid, 0);
        g++;
        @(negedge clk);
      end
      check("b_gap_len", g, 3);
    end

    // Reset after the 7th byte is accepted aborts the frame
    set_req_a(2'd0, 8'h7E, 16'hBEEF, 32'h01234567, 32'h0, 32'h0, 32'h0);
    accept_a(1'b0, "abort");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus_a.tx_valid && bus_a.tx_ready) n++;
      if (n == 7) break;
      @(negedge clk);
    end
    check("abort_seven", n, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_tx_valid", bus_a.tx_valid, 0);
    check("abort_rsp_ready", bus_a.rsp_ready, 1);
    check("abort_busy", bus_a.busy, 0);
    check("abort_frame_cnt", bus_a.frame_cnt, 0);
    exp_a.delete();
    exp_b.delete();
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    set_req_a(2'd2, 8'h44, 16'h5566, 32'h0, 32'h0, 32'h0, 32'h0);
    accept_a(1'b0, "post_rst");
    wait_done_a(1, "post_rst", vcnt);
    check("post_rst_len", vcnt + 1, 6);

    check("a_queue_drained", exp_a.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
